// File: rtl/store_merge.sv
// store_merge: sub-word store unit for the multicycle CPU.
// Narrows a register value to byte/halfword/word and performs an aligned
// read-modify-write on a word-wide data memory port.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, size, addr,  request handshake from the control FSM; size
//   wdata               00 byte, 01 half, 10 word, 11 illegal
//   busy, done, err     status: busy while in flight, one-cycle done/err pulses
//   mem_addr, mem_re,   word-wide memory port; requests held until mem_ready
//   mem_we, mem_wdata,
//   mem_rdata, mem_ready
module store_merge (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] mem_addr,
   output logic        mem_re,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   typedef enum logic [2:0] {StIdle, StRead, StWrite, StFin, StFault} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   // Only the low halfword is needed for the merge; word stores bypass it.
   logic [15:0] wdata_q, wdata_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        fault;
   logic [31:0] merged;

   always_comb begin
      fault = (size == 2'b11) ||
              ((size == 2'b01) && addr[0]) ||
              ((size == 2'b10) && (addr[1:0] != 2'b00));
   end

   // Replace the addressed lane(s) of the read word; everything else passes through.
   always_comb begin
      merged = mem_rdata;
      if (size_q == 2'b00) begin
         unique case (addr_q[1:0])
            2'b00: merged[7:0]   = wdata_q[7:0];
            2'b01: merged[15:8]  = wdata_q[7:0];
            2'b10: merged[23:16] = wdata_q[7:0];
            2'b11: merged[31:24] = wdata_q[7:0];
         endcase
      end else if (addr_q[1]) begin
         merged[31:16] = wdata_q;
      end else begin
         merged[15:0] = wdata_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      size_d      = size_q;
      wdata_d     = wdata_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               addr_d  = addr;
               size_d  = size;
               wdata_d = wdata[15:0];
               if (fault) begin
                  state_d = StFault;
               end else if (size == 2'b10) begin
                  state_d     = StWrite;
                  mem_wdata_d = wdata;
               end else begin
                  state_d = StRead;
               end
            end
         end
         StRead: begin
            if (mem_ready) begin
               mem_wdata_d = merged;
               state_d     = StWrite;
            end
         end
         StWrite: begin
            if (mem_ready) state_d = StFin;
         end
         StFin:   state_d = StIdle;
         StFault: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         addr_q      <= 32'h0;
         size_q      <= 2'b00;
         wdata_q     <= 16'h0;
         mem_wdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         wdata_q     <= wdata_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   always_comb begin
      busy      = (state_q != StIdle);
      done      = (state_q == StFin);
      err       = (state_q == StFault);
      mem_re    = (state_q == StRead);
      mem_we    = (state_q == StWrite);
      mem_addr  = {addr_q[31:2], 2'b00};
      mem_wdata = mem_wdata_q;
   end

endmodule
